seq_pattern_tx: RTL and testbench

Serial pattern transmitter: the source end of the bit-serial sequence-detector path. Accepts a W-bit pattern with a start/ready handshake and shifts it out MSB-first on a single-bit line, once or repeated, with an optional idle gap between passes. It drives the `din` input of downstream sequence detectors such as the 1001 detector, so the whole serial path can be exercised in-system without a testbench driving `din` by hand.

---
 rtl/seq_pattern_tx_if.sv | 29 ++
 rtl/seq_pattern_tx.sv | 124 ++++++++++++
 tb/tb_seq_pattern_tx.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/seq_pattern_tx_if.sv
// rtl/seq_pattern_tx_if.sv - start/ready request and serial output bundle for seq_pattern_tx
interface seq_pattern_tx_if #(
  parameter int W     = 4,
  parameter int CNT_W = 8,
  parameter int GAP_W = 4
);
  logic             start;
  logic [W-1:0]     pattern;
  logic [CNT_W-1:0] repeat_cnt;
  logic [GAP_W-1:0] gap;
  logic             abort;
  logic             ready;
  logic             busy;
  logic             dout;
  logic             dout_valid;
  logic             done;

  // Requester side: issues transmissions, observes status and the serial line
  modport master (
    output start, pattern, repeat_cnt, gap, abort,
    input  ready, busy, dout, dout_valid, done
  );

  // Transmitter side
  modport slave (
    input  start, pattern, repeat_cnt, gap, abort,
    output ready, busy, dout, dout_valid, done
  );
endinterface

// File: rtl/seq_pattern_tx.sv
// rtl/seq_pattern_tx.sv - MSB-first serial pattern transmitter with repeat count and idle gap
module seq_pattern_tx #(
  parameter int   W        = 4,
  parameter int   CNT_W    = 8,
  parameter int   GAP_W    = 4,
  parameter logic IDLE_LVL = 1'b0
) (
  input  logic               i_clk,
  input  logic               i_rst,
  seq_pattern_tx_if.slave    bus
);

  localparam int IDX_W = (W > 2) ? $clog2(W) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(W - 1);
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [GAP_W-1:0] GAP_ONE  = GAP_W'(1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

  state_t           r_state;
  logic [W-1:0]     r_pattern;
  logic [GAP_W-1:0] r_gap;
  logic [CNT_W-1:0] r_pass_cnt;
  logic [IDX_W-1:0] r_bit_idx;
  logic [GAP_W-1:0] r_gap_cnt;
  logic             r_dout;
  logic             r_dout_valid;
  logic             r_done;
  logic             r_ready;
  logic             r_busy;

  // r_bit_idx always names the bit currently presented on dout, so the
  // decision to end a pass is taken on the edge that retires bit 0.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_state      <= ST_IDLE;
      r_pattern    <= '0;
      r_gap        <= '0;
      r_pass_cnt   <= '0;
      r_bit_idx    <= '0;
      r_gap_cnt    <= '0;
      r_dout       <= IDLE_LVL;
      r_dout_valid <= 1'b0;
      r_done       <= 1'b0;
      r_ready      <= 1'b1;
      r_busy       <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (bus.start && !bus.abort) begin
            r_pattern    <= bus.pattern;
            r_gap        <= bus.gap;
            r_pass_cnt   <= bus.repeat_cnt;
            r_bit_idx    <= LAST_IDX;
            r_dout       <= bus.pattern[W-1];
            r_dout_valid <= 1'b1;
            r_ready      <= 1'b0;
            r_busy       <= 1'b1;
            r_state      <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          if (bus.abort) begin
            r_state      <= ST_IDLE;
            r_dout       <= IDLE_LVL;
            r_dout_valid <= 1'b0;
            r_ready      <= 1'b1;
            r_busy       <= 1'b0;
          end else if (r_bit_idx != '0) begin
            r_bit_idx <= r_bit_idx - IDX_ONE;
            r_dout    <= r_pattern[r_bit_idx - IDX_ONE];
          end else if (r_pass_cnt == '0) begin
            r_state      <= ST_IDLE;
            r_dout       <= IDLE_LVL;
            r_dout_valid <= 1'b0;
            r_ready      <= 1'b1;
            r_busy       <= 1'b0;
            r_done       <= 1'b1;
          end else if (r_gap == '0) begin
            r_pass_cnt <= r_pass_cnt - CNT_ONE;
            r_bit_idx  <= LAST_IDX;
            r_dout     <= r_pattern[W-1];
          end else begin
            r_pass_cnt   <= r_pass_cnt - CNT_ONE;
            r_gap_cnt    <= r_gap - GAP_ONE;
            r_dout       <= IDLE_LVL;
            r_dout_valid <= 1'b0;
            r_state      <= ST_GAP;
          end
        end
        ST_GAP: begin
          if (bus.abort) begin
            r_state      <= ST_IDLE;
            r_dout       <= IDLE_LVL;
            r_dout_valid <= 1'b0;
            r_ready      <= 1'b1;
            r_busy       <= 1'b0;
          end else if (r_gap_cnt == '0) begin
            r_bit_idx    <= LAST_IDX;
            r_dout       <= r_pattern[W-1];
            r_dout_valid <= 1'b1;
            r_state      <= ST_SHIFT;
          end else begin
            r_gap_cnt <= r_gap_cnt - GAP_ONE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.ready      = r_ready;
  assign bus.busy       = r_busy;
  assign bus.dout       = r_dout;
  assign bus.dout_valid = r_dout_valid;
  assign bus.done       = r_done;

endmodule

// File: tb/tb_seq_pattern_tx.sv
// tb/tb_seq_pattern_tx.sv - directed self-checking bench for seq_pattern_tx
module tb_seq_pattern_tx;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  seq_pattern_tx_if #(.W(4), .CNT_W(8), .GAP_W(4)) bus_if ();

  seq_pattern_tx #(.W(4), .CNT_W(8), .GAP_W(4), .IDLE_LVL(1'b0)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus_if.slave)
  );

  // Free-running clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_bit(input string tag, input logic b);
    chk({tag, " dout"}, 32'(bus_if.dout), 32'(b));
    chk({tag, " valid"}, 32'(bus_if.dout_valid), 32'd1);
    chk({tag, " busy"}, 32'(bus_if.busy), 32'd1);
    chk({tag, " ready"}, 32'(bus_if.ready), 32'd0);
  endtask

  task automatic chk_idle_gap(input string tag);
    chk({tag, " dout"}, 32'(bus_if.dout), 32'd0);
    chk({tag, " valid"}, 32'(bus_if.dout_valid), 32'd0);
    chk({tag, " busy"}, 32'(bus_if.busy), 32'd1);
  endtask

  task automatic chk_done(input string tag, input logic exp_done);
    chk({tag, " done"}, 32'(bus_if.done), 32'(exp_done));
    chk({tag, " ready"}, 32'(bus_if.ready), 32'd1);
    chk({tag, " busy"}, 32'(bus_if.busy), 32'd0);
    chk({tag, " valid"}, 32'(bus_if.dout_valid), 32'd0);
    chk({tag, " dout"}, 32'(bus_if.dout), 32'd0);
  endtask

  // Drive a request for one edge, then release start
  task automatic send(input logic [3:0] p, input logic [7:0] rc, input logic [3:0] g);
    bus_if.start      = 1'b1;
    bus_if.pattern    = p;
    bus_if.repeat_cnt = rc;
    bus_if.gap        = g;
    step();
    bus_if.start = 1'b0;
  endtask

  // Directed test sequence
  initial begin
    logic [3:0]  pat;
    logic [3:0]  sh;
    logic [11:0] stream;
    int          hits;

    total = 0;
    bad   = 0;
    rst   = 1'b0;
    bus_if.start      = 1'b0;
    bus_if.pattern    = '0;
    bus_if.repeat_cnt = '0;
    bus_if.gap        = '0;
    bus_if.abort      = 1'b0;
    step();
    step();
    chk_done("reset", 1'b0);
    rst = 1'b1;
    step();
    chk_done("post-reset idle", 1'b0);

    // Single pass 1001
    pat = 4'b1001;
    send(pat, 8'd0, 4'd0);
    for (int i = 0; i < 4; i++) begin
      chk_bit($sformatf("single bit%0d", i), pat[3-i]);
      step();
    end
    chk_done("single done", 1'b1);
    step();
    chk_done("single done drop", 1'b0);

    // Three back-to-back passes of 1001 into a 1001 detector model
    pat    = 4'b1001;
    stream = 12'b1001_1001_1001;
    sh     = '0;
    hits   = 0;
    send(pat, 8'd2, 4'd0);
    for (int i = 0; i < 12; i++) begin
      chk_bit($sformatf("b2b bit%0d", i), stream[11-i]);
      sh = {sh[2:0], bus_if.dout};
      if (bus_if.dout_valid && sh == 4'b1001) hits++;
      step();
    end
    chk_done("b2b done", 1'b1);
    chk("b2b detector hits", 32'(hits), 32'd3);
    step();

    // Two passes of 1011 with a 2-cycle gap
    pat = 4'b1011;
    send(pat, 8'd1, 4'd2);
    for (int i = 0; i < 4; i++) begin
      chk_bit($sformatf("gap p0 bit%0d", i), pat[3-i]);
      step();
    end
    chk_idle_gap("gap cyc0");
    step();
    chk_idle_gap("gap cyc1");
    step();
    for (int i = 0; i < 4; i++) begin
      chk_bit($sformatf("gap p1 bit%0d", i), pat[3-i]);
      step();
    end
    chk_done("gap done", 1'b1);
    step();

    // start while busy is ignored
    pat = 4'b1001;
    send(pat, 8'd0, 4'd0);
    chk_bit("busy-start bit0", pat[3]);
    bus_if.start      = 1'b1;
    bus_if.pattern    = 4'b0110;
    bus_if.repeat_cnt = 8'd5;
    bus_if.gap        = 4'd3;
    step();
    bus_if.start = 1'b0;
    for (int i = 1; i < 4; i++) begin
      chk_bit($sformatf("busy-start bit%0d", i), pat[3-i]);
      step();
    end
    chk_done("busy-start done", 1'b1);

    // New start in the done cycle: first bit of 0110 on the next cycle
    pat = 4'b0110;
    send(pat, 8'd0, 4'd0);
    chk("chain done cleared", 32'(bus_if.done), 32'd0);
    for (int i = 0; i < 4; i++) begin
      chk_bit($sformatf("chain bit%0d", i), pat[3-i]);
      step();
    end
    chk_done("chain done", 1'b1);
    step();

    // Abort while the second bit is on the line
    pat = 4'b1100;
    send(pat, 8'd3, 4'd0);
    chk_bit("abort bit0", pat[3]);
    step();
    chk_bit("abort bit1", pat[2]);
    bus_if.abort = 1'b1;
    step();
    bus_if.abort = 1'b0;
    chk_done("abort idle", 1'b0);
    step();
    chk_done("abort no done", 1'b0);

    // Reset asserted during a gap
    pat = 4'b1011;
    send(pat, 8'd1, 4'd3);
    for (int i = 0; i < 4; i++) begin
      chk_bit($sformatf("rstgap bit%0d", i), pat[3-i]);
      step();
    end
    chk_idle_gap("rstgap gap");
    rst = 1'b0;
    step();
    rst = 1'b1;
    chk_done("rstgap reset", 1'b0);
    step();
    chk_done("rstgap stays idle", 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Safety bound so the run always terminates
  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
